// File: rtl/mac_pkg.sv
// Shared types and helpers for the mac_accum accumulate stage.
package mac_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Counter width for a group of `terms` products, never below one bit.
  function automatic int cnt_w(input int terms);
    return (terms <= 1) ? 1 : $clog2(terms);
  endfunction

endpackage

// File: rtl/mac_accum_term_counter.sv
// Term counter for one accumulation group: counts accepted terms and flags the last.
module term_counter #(
  parameter int TERMS = 8,
  parameter int CW    = 3
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(TERMS - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (inc)  count <= last ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/mac_accum.sv
// Accumulates TERMS unsigned products per group and hands the sum off on valid/ready.
// Optional MAC_SAT_EN: saturate to all-ones on carry instead of wrapping.
module mac_accum
  import mac_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int TERMS     = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] prod,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic                 ovf
);

  localparam int CW = cnt_w(TERMS);

  state_e               state;
  logic [DATAWIDTH-1:0] acc;
  logic                 ovf_acc;
  logic [CW-1:0]        count;
  logic                 last;
  logic                 accept;
  logic [DATAWIDTH:0]   add_full;
  logic                 carry;
  logic [DATAWIDTH-1:0] add_res;

  assign in_ready = (state == ACCUM) && !clear;
  assign accept   = in_valid && in_ready;
  assign add_full = {1'b0, acc} + {1'b0, prod};
  assign carry    = add_full[DATAWIDTH];

`ifdef MAC_SAT_EN
  // Once clamped, any further nonzero term carries again, so the clamp sticks.
  assign add_res = carry ? '1 : add_full[DATAWIDTH-1:0];
`else
  assign add_res = add_full[DATAWIDTH-1:0];
`endif

  term_counter #(.TERMS(TERMS), .CW(CW)) u_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .clr   (clear),
    .inc   (accept),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ACCUM;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clear) begin
      // Abort: drop the partial group and any undelivered sum; sum/ovf keep last value.
      state     <= ACCUM;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (accept) begin
          if (last) begin
            sum       <= add_res;
            ovf       <= ovf_acc | carry;
            sum_valid <= 1'b1;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            state     <= HOLD;
          end else begin
            acc       <= add_res;
            ovf_acc   <= ovf_acc | carry;
          end
        end
        HOLD: if (sum_ready) begin
          sum_valid <= 1'b0;
          state     <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
